minkowski_net_14_layer_pipeline_psum_accum: RTL and testbench

MINKOWSKI_NET_14_LAYER_PIPELINE_PSUM_ACCUM -- requirements
Module: minkowski_net_14_layer_pipeline_psum_accum

---
 rtl/minkowski_net_14_layer_pipeline_psum_accum.sv | 137 +++++++++++++
 tb/tb_minkowski_net_14_layer_pipeline_psum_accum.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/minkowski_net_14_layer_pipeline_psum_accum.sv
// ---------------------------------------------------------------------------
// minkowski_net_14_layer_pipeline_psum_accum
//
// Accumulates signed partial products, one per kernel offset, into a
// saturating accumulator. When the beat flagged as last arrives, the module
// requantizes the point's sum to OUT_W bits. Requantization is a rounding
// arithmetic right shift, an optional ReLU, and then saturation. The result
// is presented through a valid/ready output register with a 1-cycle latency.
//
// Ports
//   ap_clk     : clock, rising edge
//   ap_rst_n   : asynchronous active-low reset
//   in_data    : signed partial product (IN_W bits)
//   in_last    : marks the final kernel offset of the current output point
//   in_valid   : input handshake valid
//   in_ready   : input handshake ready, = !out_valid | out_ready
//   out_data   : signed requantized feature (OUT_W bits)
//   out_ovf    : accumulator saturated at some point during this output
//   out_idx    : output point sequence number, wraps at 16 bits
//   out_valid  : output handshake valid
//   out_ready  : output handshake ready
// ---------------------------------------------------------------------------
module minkowski_net_14_layer_pipeline_psum_accum #(
  parameter int IN_W  = 13,
  parameter int ACC_W = 20,
  parameter int OUT_W = 8,
  parameter int SHIFT = 6,
  parameter int RELU  = 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic [15:0]      out_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  // One guard bit above the accumulator. This bit detects overflow on the
  // add, and it also holds the rounding add without wrapping.
  localparam int SW = ACC_W + 1;

  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;
  logic [15:0]      pt_cnt_reg;
  logic             out_valid_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic             out_ovf_reg;
  logic [15:0]      out_idx_reg;

  logic             fire;
  logic             fire_last;
  logic [SW-1:0]    sum_wide;
  logic             sum_sat_hit;
  logic [ACC_W-1:0] sum_sat;
  logic signed [SW-1:0] rnd_wide;
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] relu_val;
  logic [SW-OUT_W:0]    top_bits;
  logic [OUT_W-1:0]     q_next;

  assign in_ready  = !out_valid_reg | out_ready;
  assign fire      = in_valid & in_ready;
  assign fire_last = fire & in_last;

  // Sign-extend both operands into the guard width and add them.
  assign sum_wide = {acc_reg[ACC_W-1], acc_reg}
                  + {{(SW-IN_W){in_data[IN_W-1]}}, in_data};

  // Overflow shows up when the guard bit and the accumulator MSB disagree.
  // In that case the guard bit gives the true sign of the sum.
  assign sum_sat_hit = sum_wide[SW-1] ^ sum_wide[SW-2];

  always_comb begin
    sum_sat = sum_wide[ACC_W-1:0];
    if (sum_sat_hit) begin
      if (sum_wide[SW-1]) sum_sat = {1'b1, {(ACC_W-1){1'b0}}};
      else                sum_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Round half up, then shift arithmetically (floor).
  assign rnd_wide = $signed({sum_sat[ACC_W-1], sum_sat}
                  + {{(SW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}});
  assign shifted  = rnd_wide >>> SHIFT;
  assign relu_val = ((RELU != 0) && shifted[SW-1]) ? '0 : shifted;
  assign top_bits = relu_val[SW-1:OUT_W-1];

  // The value fits in OUT_W bits only if all the bits above the output sign
  // bit match that sign bit.
  always_comb begin
    q_next = relu_val[OUT_W-1:0];
    if (!((&top_bits) || !(|top_bits))) begin
      if (relu_val[SW-1]) q_next = {1'b1, {(OUT_W-1){1'b0}}};
      else                q_next = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      pt_cnt_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ovf_reg   <= 1'b0;
      out_idx_reg   <= '0;
    end else begin
      if (fire) begin
        if (in_last) begin
          acc_reg       <= '0;
          ovf_reg       <= 1'b0;
          out_data_reg  <= q_next;
          out_ovf_reg   <= ovf_reg | sum_sat_hit;
          out_idx_reg   <= pt_cnt_reg;
          pt_cnt_reg    <= pt_cnt_reg + 16'd1;
          out_valid_reg <= 1'b1;
        end else begin
          acc_reg <= sum_sat;
          ovf_reg <= ovf_reg | sum_sat_hit;
        end
      end
      // If a new result is loaded on this edge, it takes priority over the drain.
      if (out_ready && !fire_last) out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_idx   = out_idx_reg;

endmodule

// File: tb/tb_minkowski_net_14_layer_pipeline_psum_accum.sv
// ---------------------------------------------------------------------------
// Testbench for minkowski_net_14_layer_pipeline_psum_accum.
// This bench instantiates two copies of the design, one with RELU=1 and one
// with RELU=0, and drives both with the same stimulus. An integer-arithmetic
// reference model predicts the outputs, and both copies are compared against
// it on every falling clock edge. Directed vectors then check literal values.
// ---------------------------------------------------------------------------
module tb_minkowski_net_14_layer_pipeline_psum_accum;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic signed [12:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;

  logic              in_ready1, in_ready0;
  logic signed [7:0] o_data1, o_data0;
  logic              o_ovf1, o_ovf0;
  logic [15:0]       o_idx1, o_idx0;
  logic              o_valid1, o_valid0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 ap_clk = ~ap_clk;

  minkowski_net_14_layer_pipeline_psum_accum #(
    .IN_W(13), .ACC_W(20), .OUT_W(8), .SHIFT(6), .RELU(1)
  ) dut1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready1), .out_data(o_data1),
    .out_ovf(o_ovf1), .out_idx(o_idx1), .out_valid(o_valid1), .out_ready(out_ready)
  );

  minkowski_net_14_layer_pipeline_psum_accum #(
    .IN_W(13), .ACC_W(20), .OUT_W(8), .SHIFT(6), .RELU(0)
  ) dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready0), .out_data(o_data0),
    .out_ovf(o_ovf0), .out_idx(o_idx0), .out_valid(o_valid0), .out_ready(out_ready)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  localparam longint ACC_MAX = (64'sd1 <<< 19) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< 19);

  longint m_acc;
  bit     m_ovf;
  int     m_pt;
  bit     m_valid;
  longint m_d1, m_d0;
  bit     m_o;
  int     m_idx;

  function automatic longint requant(input longint s, input bit relu);
    longint r;
    r = (s + 32) >>> 6;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_acc = 0; m_ovf = 0; m_pt = 0; m_valid = 0;
      m_d1 = 0; m_d0 = 0; m_o = 0; m_idx = 0;
    end else begin
      bit rdy, take, sat;
      longint s;
      rdy  = !m_valid || out_ready;
      take = in_valid && rdy;
      if (take) begin
        s = m_acc + longint'(in_data);
        sat = 0;
        if (s > ACC_MAX) begin s = ACC_MAX; sat = 1; end
        if (s < ACC_MIN) begin s = ACC_MIN; sat = 1; end
        if (in_last) begin
          m_d1 = requant(s, 1'b1);
          m_d0 = requant(s, 1'b0);
          m_o = m_ovf || sat;
          m_idx = m_pt;
          m_pt = (m_pt + 1) % 65536;
          m_acc = 0; m_ovf = 0;
          m_valid = 1;
        end else begin
          m_acc = s;
          m_ovf = m_ovf || sat;
        end
      end
      if (out_ready && !(take && in_last)) m_valid = 0;
    end
  end

  // Continuous comparison against the model.
  always @(negedge ap_clk) begin
    chk("cmp_valid1", o_valid1, m_valid);
    chk("cmp_valid0", o_valid0, m_valid);
    chk("cmp_in_ready1", in_ready1, (!m_valid || out_ready));
    chk("cmp_in_ready0", in_ready0, (!m_valid || out_ready));
    if (m_valid || !ap_rst_n) begin
      chk("cmp_data1", o_data1, m_d1);
      chk("cmp_data0", o_data0, m_d0);
      chk("cmp_ovf1", o_ovf1, m_o);
      chk("cmp_ovf0", o_ovf0, m_o);
      chk("cmp_idx1", o_idx1, m_idx);
      chk("cmp_idx0", o_idx0, m_idx);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Call this task at posedge+2. It returns at posedge+2, just after the
  // edge that accepted the beat.
  task automatic beat(input int d, input bit last);
    int n;
    in_valid = 1'b1;
    in_data  = 13'(d);
    in_last  = last;
    n = 0;
    forever begin
      @(negedge ap_clk);
      if (in_ready1) break;
      n++;
      if (n > 100) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    @(posedge ap_clk); #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic burst(input int n, input int d);
    for (int i = 0; i < n; i++) beat(d, i == n - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge ap_clk); #2; end
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_valid", o_valid1, 0);
    chk("rst_data", o_data1, 0);
    chk("rst_idx", o_idx1, 0);
    chk("rst_in_ready", in_ready1, 1);
    repeat (3) @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    idle(1);

    // Basic three-beat point
    beat(100, 0); beat(200, 0); beat(-50, 1);
    @(negedge ap_clk);
    chk("t30_valid", o_valid1, 1);
    chk("t30_data", o_data1, 4);
    chk("t30_model_data", m_d1, 4);
    chk("t30_ovf", o_ovf1, 0);
    chk("t30_idx", o_idx1, 0);
    $display("t30 point: data=%0d ovf=%0d idx=%0d", o_data1, o_ovf1, o_idx1);
    @(posedge ap_clk); #2;

    // Negative sum, with and without ReLU
    beat(-100, 0); beat(-200, 1);
    @(negedge ap_clk);
    chk("t31_relu_data", o_data1, 0);
    chk("t31_norelu_data", o_data0, -5);
    chk("t31_model_norelu", m_d0, -5);
    chk("t31_idx", o_idx1, 1);
    $display("t31 point: relu=%0d norelu=%0d idx=%0d", o_data1, o_data0, o_idx1);
    @(posedge ap_clk); #2;

    // Large sums: output saturation, then accumulator saturation
    burst(20, 4095);
    @(negedge ap_clk);
    chk("t32a_data", o_data1, 127);
    chk("t32a_ovf", o_ovf1, 0);
    $display("t32a point: data=%0d ovf=%0d", o_data1, o_ovf1);
    @(posedge ap_clk); #2;
    burst(200, 4095);
    @(negedge ap_clk);
    chk("t32b_data", o_data1, 127);
    chk("t32b_ovf", o_ovf1, 1);
    chk("t32b_model_ovf", m_o, 1);
    chk("t32b_idx", o_idx1, 3);
    $display("t32b point: data=%0d ovf=%0d", o_data1, o_ovf1);
    @(posedge ap_clk); #2;
    idle(1);

    // Backpressure: output frozen, then drained and refilled on one edge
    out_ready = 1'b0;
    beat(320, 1);
    in_valid = 1'b1; in_data = 13'sd64; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      chk("t33_hold_ready", in_ready1, 0);
      chk("t33_hold_valid", o_valid1, 1);
      chk("t33_hold_data", o_data1, 5);
      chk("t33_hold_idx", o_idx1, 4);
    end
    @(posedge ap_clk); #2;
    out_ready = 1'b1;
    @(posedge ap_clk); #2;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge ap_clk);
    chk("t33_valid_kept", o_valid1, 1);
    chk("t33_new_data", o_data1, 1);
    chk("t33_new_idx", o_idx1, 5);
    $display("t33 point: data=%0d idx=%0d", o_data1, o_idx1);
    @(negedge ap_clk);
    chk("t33_drained", o_valid1, 0);
    @(posedge ap_clk); #2;

    // Asynchronous reset in the middle of a point
    beat(500, 0); beat(500, 0);
    ap_rst_n = 1'b0;
    #1;
    chk("t34_rst_valid", o_valid1, 0);
    chk("t34_rst_data", o_data1, 0);
    chk("t34_rst_ovf", o_ovf1, 0);
    chk("t34_rst_idx", o_idx1, 0);
    @(posedge ap_clk); @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
    idle(1);
    beat(128, 1);
    @(negedge ap_clk);
    chk("t34_data", o_data1, 2);
    chk("t34_idx", o_idx1, 0);
    $display("t34 point: data=%0d idx=%0d", o_data1, o_idx1);
    @(posedge ap_clk); #2;

    // Index wrap: 65537 single-beat points, one per cycle
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
    idle(1);
    in_valid = 1'b1; in_last = 1'b1; in_data = '0;
    for (int i = 0; i < 65537; i++) begin
      @(posedge ap_clk); #1;
      chk("t35_idx_seq", o_idx1, i % 65536);
    end
    #1 in_valid = 1'b0; in_last = 1'b0;
    @(negedge ap_clk);
    chk("t35_wrap_idx", o_idx1, 0);
    $display("t35 final point: idx=%0d", o_idx1);
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
